// File: rtl/obi_mem_responder_pkg.sv
// obi_mem_responder_pkg: shared OBI types, defaults and address decode helper
package obi_mem_responder_pkg;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;
  localparam int unsigned MIN_LATENCY = 1;
  localparam int unsigned MAX_LATENCY = 4;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_stage_t;
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base, input int unsigned num_words);
    logic [31:0] offset;
    offset = addr - base;
    return {1'b0, offset} < (33'(num_words) << 2);
  endfunction
endpackage

// File: rtl/obi_mem_sram_bank.sv
// obi_mem_sram_bank: single-port byte-enabled SRAM with registered read data
module obi_mem_sram_bank #(
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_en,
  input  logic                         i_we,
  input  logic [3:0]                   i_be,
  input  logic [$clog2(NUM_WORDS)-1:0] i_addr,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);
  logic [31:0] r_mem [NUM_WORDS];
  logic [31:0] r_rdata;
  // enabled writes update selected bytes; enabled reads capture the addressed word
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) for (int i = 0; i < 4; i++) if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    if (i_en && !i_we) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: fixed-latency OBI responder backed by a word-addressed SRAM
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = ERR_RDATA_DEFAULT
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o,
  input  logic      gnt_stall_i,
  output logic      busy_o,
  output logic      err_o
);
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("NUM_WORDS must be a power of two >= 2");
  end
  if (RESP_LATENCY < MIN_LATENCY || RESP_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("RESP_LATENCY out of range");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RESP_LATENCY + 1) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING out of range");
  end
  logic [CW-1:0] r_cnt;
  resp_stage_t   r_pipe [RESP_LATENCY];
  logic          r_rd_head;
  logic          w_gnt, w_acc, w_in_range, w_rd_ok;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_sram_rdata;
  resp_stage_t   w_head, w_out;
  assign w_gnt      = slave_req_i.req && !gnt_stall_i && !rst_i && (r_cnt < CW'(MAX_OUTSTANDING));
  assign w_acc      = slave_req_i.req && w_gnt;
  assign w_in_range = addr_in_range(slave_req_i.addr, BASE_ADDR, NUM_WORDS);
  assign w_idx      = AW'((slave_req_i.addr - BASE_ADDR) >> 2);
  assign w_rd_ok    = w_acc && !slave_req_i.we && w_in_range;
  // the bank's read register is the data half of the first stage for in-range reads
  assign w_head = '{valid: r_pipe[0].valid, err: r_pipe[0].err, rdata: r_rd_head ? w_sram_rdata : r_pipe[0].rdata};
  assign w_out  = (RESP_LATENCY == 1) ? w_head : r_pipe[RESP_LATENCY-1];
  obi_mem_sram_bank #(.NUM_WORDS(NUM_WORDS)) u_bank (
    .i_clk  (clk_i),
    .i_en   (w_acc && w_in_range),
    .i_we   (slave_req_i.we),
    .i_be   (slave_req_i.be),
    .i_addr (w_idx),
    .i_wdata(slave_req_i.wdata),
    .o_rdata(w_sram_rdata)
  );
  // outstanding counter and response shift register; reset drops in-flight responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_rd_head <= 1'b0;
      for (int k = 0; k < RESP_LATENCY; k++) r_pipe[k] <= '0;
    end else begin
      r_cnt     <= r_cnt + CW'(w_acc) - CW'(w_out.valid);
      r_rd_head <= w_rd_ok;
      r_pipe[0] <= '{valid: w_acc, err: w_acc && !w_in_range,
                     rdata: (w_acc && !slave_req_i.we && !w_in_range) ? ERR_RDATA : 32'h0};
      for (int k = 1; k < RESP_LATENCY; k++) r_pipe[k] <= (k == 1) ? w_head : r_pipe[k-1];
    end
  end
  assign slave_resp_o = '{gnt: w_gnt, rvalid: w_out.valid, rdata: w_out.valid ? w_out.rdata : 32'h0};
  assign busy_o       = r_cnt != '0;
  assign err_o        = w_out.valid && w_out.err;
endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
Fixed-latency OBI slave (responder) that terminates the external-crossbar slave port with a word-addressed SRAM. It answers the OBI transactions that the external bus forwards from X-HEEP and CGRA masters. It is the responder-side counterpart of the accelerator OBI master ports. It supports pipelined outstanding transactions, byte-enabled writes, an error response for out-of-range accesses, and a test hook that withholds grants.

Parameters:
BASE_ADDR, 32'h0, byte address of word 0
NUM_WORDS, 1024, SRAM depth in 32-bit words (power of two, >=2)
RESP_LATENCY, 1, cycles from grant to rvalid (1..4)
MAX_OUTSTANDING, 2, granted-but-unanswered transaction limit (1..RESP_LATENCY+1)
ERR_RDATA, 32'hBADCAB1E, rdata returned on out-of-range reads

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
slave_req_i  in  obi_req_t  OBI request (req, we, be[3:0], addr[31:0], wdata[31:0])
slave_resp_o  out  obi_resp_t  OBI response (gnt, rvalid, rdata[31:0])
gnt_stall_i  in  1  withholds gnt while high (backpressure test hook)
busy_o  out  1  high while any transaction is outstanding
err_o  out  1  one-cycle pulse, aligned with the rvalid of an out-of-range access

Behaviour:
- Clock/reset: single clock clk_i; synchronous, active-high reset rst_i.
- Reset values: gnt 0 (combinational, forced low while rst_i), rvalid 0, rdata 0, busy_o 0, err_o 0, outstanding count 0, all pipeline valid bits 0. SRAM contents are not reset.
- Grant: gnt = req & ~gnt_stall_i & (outstanding < MAX_OUTSTANDING). Purely combinational, with no dependency on same-cycle rvalid. A transaction is accepted on the clock edge where req & gnt.
- Address decode: offset = addr - BASE_ADDR, modulo 2^32. In range iff offset < NUM_WORDS*4. Word index = offset[2 +: $clog2(NUM_WORDS)]. addr[1:0] is ignored.
- Write (we=1, in range): for each be[i] set, SRAM byte i is updated at the accept edge. Bytes with be[i]=0 are unchanged. be=0 writes nothing but still gets a response.
- Read (we=0, in range): the SRAM is read at the accept edge.
- Response pipeline: a RESP_LATENCY-deep shift register of {valid, err, rdata}. rvalid is asserted exactly RESP_LATENCY cycles after the accept edge, for one cycle per transaction, in acceptance order.
  - Reads return SRAM data.
  - Writes return rdata 0.
  - Out-of-range reads return ERR_RDATA with err_o=1.
  - Out-of-range writes have no SRAM effect, return rdata 0, and set err_o=1.
- rvalid is never backpressured (OBI). When rvalid=0, rdata is held at 0.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the written data. A read and a write cannot be accepted in the same cycle (single port).
- Outstanding counter:
  - increments on accept;
  - decrements on rvalid;
  - unchanged when both occur in the same cycle;
  - never exceeds MAX_OUTSTANDING.
- busy_o = (outstanding != 0).
- Back-to-back: with MAX_OUTSTANDING >= RESP_LATENCY+1, gnt may stay high every cycle, giving one transaction per cycle. With a smaller limit, gnt drops while the counter is full and recovers the cycle after the counter decrements.
- Request stability: while req=1 and gnt=0, the requester must hold its request stable. The block samples request fields only at the accept edge.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset) and the counter clears. A write accepted on the reset edge is not performed.

Decomposition:
- Shared package obi_mem_responder_pkg:
  - resp_stage_t struct {valid, err, rdata};
  - localparams for ERR_RDATA default and the latency bounds;
  - function addr_in_range().
- Parameter legality is checked with elaboration-time assertions.
- One natural sub-module, obi_mem_sram_bank: a single-port, byte-enabled, synchronous-read SRAM model that can be swapped for a technology macro.
- The top module holds decode, grant logic, counter and response pipeline.

Test Plan:
- Single write then read: write addr 0x10, be=4'hF, wdata 0xDEADBEEF, LAT=1. Required: rvalid 1 cycle after accept with rdata 0. The following read of 0x10 returns 0xDEADBEEF.
- Byte enables: word 0x20 preloaded with 0x11223344. Write be=4'b0101, wdata 0xAABBCCDD. A read of 0x20 returns 0x11BB33DD.
- Streaming: LAT=2, MAX_OUTSTANDING=3, 8 back-to-back reads with req held high. Required: gnt high every cycle, 8 rvalids on consecutive cycles starting 2 cycles after the first accept, in order, busy_o falling after the last.
- Throttling: LAT=3, MAX_OUTSTANDING=1, continuous reads. Required: gnt high only every 4th cycle, counter never exceeds 1.
  - gnt_stall_i=1 for 5 cycles: no accepts during the stall, and the request completes normally afterwards.
- Out-of-range: read of BASE_ADDR+NUM_WORDS*4. Required: rdata 0xBADCAB1E with err_o pulse. Out-of-range write: rdata 0, err_o pulse, SRAM unchanged.
- Reset mid-flight: LAT=4, 2 reads accepted, rst_i asserted 2 cycles later. Required: no rvalid ever appears, busy_o=0 the cycle after reset, and the next request is granted normally.
